axi_addr_split4k_gen: RTL and testbench

- Parametrised successor of the single-split 4KB address splitter for the iDMA data NoC master port.
- Accepts one DMA burst request of up to 2^LENW beats of DATA_BYTES each.
- Issues it on the AXI AW/AR channel as as many sub-bursts as needed so that none crosses a 2^BOUNDARY_LOG2-byte boundary.
- Pushes one piece descriptor per issued sub-burst into an internal FIFO, so the data path can track beat/last boundaries per piece.

---
 rtl/axi_addr_split4k_gen.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_axi_addr_split4k_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_addr_split4k_gen.sv
// ---------------------------------------------------------------------------
// axi_addr_split4k_gen
//
// Purpose:
//   Takes one DMA burst request (start byte address + beat count) and issues
//   it on an AXI AW/AR address channel as one or more INCR sub-bursts so that
//   no sub-burst crosses a 2^BOUNDARY_LOG2-byte boundary. For each sub-burst
//   issued, a piece descriptor {beats-1, last-of-request} is pushed into a
//   small internal FIFO so the data path can track per-piece beat counts and
//   last flags.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   cfg_split_en             1 = split at boundaries, 0 = pass bursts whole
//   x_burst_arvld_disable    blocks acceptance of new requests
//   dma_req_valid/ready      request handshake
//   dma_req_addr/len         request start byte address, beats minus 1
//   dma_xaddr_burst_ok       1-cycle pulse after the last piece handshakes
//   o_ax*                    AXI address channel (valid/id/addr/len/size/...)
//   i_axready                AXI address channel ready
//   info_valid/ready         piece-descriptor FIFO head handshake
//   info_len/info_last       head descriptor: beats minus 1, last piece flag
//   split_active             current request issues more than one piece
//
// Optional feature (macro AXI_SPLIT_STAT_EN):
//   Adds input stat_clr and outputs stat_req_cnt[15:0] / stat_piece_cnt[15:0],
//   saturating counts of accepted requests and issued sub-bursts. Without the
//   macro these ports and counters do not exist.
// ---------------------------------------------------------------------------
module axi_addr_split4k_gen #(
    parameter int AXI_IDW       = 4,
    parameter int AXI_LOCKW     = 2,
    parameter int ID            = 0,
    parameter int ADDRW         = 32,
    parameter int LENW          = 8,
    parameter int DATA_BYTES    = 32,
    parameter int BOUNDARY_LOG2 = 12,
    parameter int INFO_DEPTH    = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cfg_split_en,
    input  logic                 x_burst_arvld_disable,
    input  logic                 dma_req_valid,
    output logic                 dma_req_ready,
    input  logic [ADDRW-1:0]     dma_req_addr,
    input  logic [LENW-1:0]      dma_req_len,
    output logic                 dma_xaddr_burst_ok,
    output logic                 o_axvalid,
    output logic [AXI_IDW-1:0]   o_axid,
    output logic [ADDRW-1:0]     o_axaddr,
    output logic [LENW-1:0]      o_axlen,
    output logic [2:0]           o_axsize,
    output logic [1:0]           o_axburst,
    output logic [AXI_LOCKW-1:0] o_axlock,
    output logic [3:0]           o_axcache,
    output logic [2:0]           o_axprot,
    input  logic                 i_axready,
    output logic                 info_valid,
    input  logic                 info_ready,
    output logic [LENW-1:0]      info_len,
    output logic                 info_last,
`ifdef AXI_SPLIT_STAT_EN
    input  logic                 stat_clr,
    output logic [15:0]          stat_req_cnt,
    output logic [15:0]          stat_piece_cnt,
`endif
    output logic                 split_active
);

    localparam int SIZE_LOG2 = $clog2(DATA_BYTES);
    localparam int BLOG      = BOUNDARY_LOG2;
    // Beats that fit in one boundary-sized window.
    localparam int SPAN_LOG2 = BLOG - SIZE_LOG2;
    // Remaining-beat counter holds 1..2^LENW, so it needs LENW+1 bits.
    localparam int RW        = LENW + 1;
    // Working width for boundary math: wide enough for both the beat count
    // and the beats-to-boundary value without truncation.
    localparam int CW        = ((RW > (BLOG + 1)) ? RW : (BLOG + 1)) + 1;
    localparam int HIW       = ADDRW - BLOG;
    localparam int PTRW      = $clog2(INFO_DEPTH);
    localparam int CNTW      = PTRW + 1;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    // Beats in the next piece starting at an address whose in-window offset
    // is 'low'. Offset bits below the beat size are discarded by the shift.
    function automatic logic [RW-1:0] calc_piece(
        input logic [BLOG-1:0] low,
        input logic [RW-1:0]   rem,
        input logic            split_en
    );
        logic [CW-1:0] to_bnd;
        logic [CW-1:0] pick;
        to_bnd = (CW'(1) << SPAN_LOG2) - (CW'(low) >> SIZE_LOG2);
        if (split_en && (to_bnd < CW'(rem))) begin
            pick = to_bnd;
        end else begin
            pick = CW'(rem);
        end
        return RW'(pick);
    endfunction

    state_t               state_q, state_d;
    logic [ADDRW-1:0]     cur_addr_q, cur_addr_d;
    logic [RW-1:0]        rem_q, rem_d;
    logic                 split_q, split_d;
    logic                 axvalid_q, axvalid_d;
    logic [ADDRW-1:0]     axaddr_q, axaddr_d;
    logic [LENW-1:0]      axlen_q, axlen_d;
    logic                 axlast_q, axlast_d;
    logic                 ok_q, ok_d;

    logic [LENW:0]        mem_q [INFO_DEPTH];
    logic [LENW:0]        mem_d [INFO_DEPTH];
    logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]      count_q, count_d;

    logic                 fifo_free;
    logic                 req_ready;
    logic                 accept;
    logic                 ax_hs;
    logic                 push;
    logic                 pop;
    logic [RW-1:0]        req_rem;
    logic [RW-1:0]        req_piece;
    logic [RW-1:0]        cur_piece;
    logic [RW-1:0]        hs_piece;

    // Handshake and request-side helpers. Ready is gated by aresetn so it
    // reads 0 while the block is held in reset.
    always_comb begin
        fifo_free = (count_q < CNTW'(INFO_DEPTH));
        req_ready = aresetn && (state_q == ST_IDLE) && !x_burst_arvld_disable && fifo_free;
        accept    = dma_req_valid && req_ready;
        ax_hs     = axvalid_q && i_axready;
        push      = ax_hs;
        pop       = (count_q != '0) && info_ready;
        req_rem   = {1'b0, dma_req_len} + RW'(1);
        req_piece = calc_piece(dma_req_addr[BLOG-1:0], req_rem, cfg_split_en);
        cur_piece = calc_piece(cur_addr_q[BLOG-1:0], rem_q, cfg_split_en);
        hs_piece  = {1'b0, axlen_q} + RW'(1);
    end

    // Request FSM. In ISSUE, valid is raised for the next piece only while a
    // descriptor slot is free; since this block is the only FIFO writer, that
    // slot cannot be taken away before the handshake. After a handshake the
    // address advances to the next window start, which is where every
    // non-final piece ends.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        split_d    = split_q;
        axvalid_d  = axvalid_q;
        axaddr_d   = axaddr_q;
        axlen_d    = axlen_q;
        axlast_d   = axlast_q;
        ok_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cur_addr_d = dma_req_addr;
                    rem_d      = req_rem;
                    split_d    = (req_piece < req_rem);
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!axvalid_q) begin
                    if (fifo_free) begin
                        axvalid_d = 1'b1;
                        axaddr_d  = cur_addr_q;
                        axlen_d   = cur_piece[LENW-1:0] - LENW'(1);
                        axlast_d  = (cur_piece == rem_q);
                    end
                end else if (i_axready) begin
                    axvalid_d  = 1'b0;
                    rem_d      = rem_q - hs_piece;
                    cur_addr_d = {cur_addr_q[ADDRW-1:BLOG] + HIW'(1), {BLOG{1'b0}}};
                    if (axlast_q) begin
                        ok_d    = 1'b1;
                        split_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Descriptor FIFO next-state: write at the tail on a handshake, advance
    // the head on a pop, count tracks the difference.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {axlen_q, axlast_q};
            wr_ptr_d        = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            split_q    <= 1'b0;
            axvalid_q  <= 1'b0;
            axaddr_q   <= '0;
            axlen_q    <= '0;
            axlast_q   <= 1'b0;
            ok_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < INFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            split_q    <= split_d;
            axvalid_q  <= axvalid_d;
            axaddr_q   <= axaddr_d;
            axlen_q    <= axlen_d;
            axlast_q   <= axlast_d;
            ok_q       <= ok_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

`ifdef AXI_SPLIT_STAT_EN
    logic [15:0] stat_req_q, stat_req_d;
    logic [15:0] stat_piece_q, stat_piece_d;

    // Saturating statistics; a clear in the same cycle as an event wins.
    always_comb begin
        stat_req_d   = stat_req_q;
        stat_piece_d = stat_piece_q;
        if (stat_clr) begin
            stat_req_d   = '0;
            stat_piece_d = '0;
        end else begin
            if (accept && (stat_req_q != 16'hFFFF)) begin
                stat_req_d = stat_req_q + 16'd1;
            end
            if (ax_hs && (stat_piece_q != 16'hFFFF)) begin
                stat_piece_d = stat_piece_q + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_req_q   <= '0;
            stat_piece_q <= '0;
        end else begin
            stat_req_q   <= stat_req_d;
            stat_piece_q <= stat_piece_d;
        end
    end

    assign stat_req_cnt   = stat_req_q;
    assign stat_piece_cnt = stat_piece_q;
`endif

    assign dma_req_ready      = req_ready;
    assign dma_xaddr_burst_ok = ok_q;
    assign o_axvalid          = axvalid_q;
    assign o_axid             = AXI_IDW'(ID);
    assign o_axaddr           = axaddr_q;
    assign o_axlen            = axlen_q;
    assign o_axsize           = 3'(SIZE_LOG2);
    assign o_axburst          = 2'b01;
    assign o_axlock           = '0;
    assign o_axcache          = 4'b0000;
    assign o_axprot           = 3'b000;
    assign info_valid         = (count_q != '0);
    assign info_len           = mem_q[rd_ptr_q][LENW:1];
    assign info_last          = mem_q[rd_ptr_q][0];
    assign split_active       = split_q;

endmodule

// File: tb/tb_axi_addr_split4k_gen.sv
// ---------------------------------------------------------------------------
// tb_axi_addr_split4k_gen
//
// Directed-vector bench for axi_addr_split4k_gen with default parameters
// (32-byte beats, AXI4 lengths, 4 KB boundary, 4-entry descriptor FIFO).
// Expected AX pieces and descriptors are queued when a request is issued;
// independent monitors pop and compare on every AX and descriptor handshake.
// ---------------------------------------------------------------------------
module tb_axi_addr_split4k_gen;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cfg_split_en;
    logic        x_burst_arvld_disable;
    logic        dma_req_valid;
    logic        dma_req_ready;
    logic [31:0] dma_req_addr;
    logic [7:0]  dma_req_len;
    logic        dma_xaddr_burst_ok;
    logic        o_axvalid;
    logic [3:0]  o_axid;
    logic [31:0] o_axaddr;
    logic [7:0]  o_axlen;
    logic [2:0]  o_axsize;
    logic [1:0]  o_axburst;
    logic [1:0]  o_axlock;
    logic [3:0]  o_axcache;
    logic [2:0]  o_axprot;
    logic        i_axready;
    logic        info_valid;
    logic        info_ready;
    logic [7:0]  info_len;
    logic        info_last;
    logic        split_active;
`ifdef AXI_SPLIT_STAT_EN
    logic        stat_clr;
    logic [15:0] stat_req_cnt;
    logic [15:0] stat_piece_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int ok_seen      = 0;
    int ok_exp       = 0;

    logic [39:0] exp_ax[$];
    logic [8:0]  exp_info[$];
    logic [39:0] ax_e;
    logic [8:0]  info_e;

    always #5 aclk = ~aclk;

    axi_addr_split4k_gen dut (
        .aclk                  (aclk),
        .aresetn               (aresetn),
        .cfg_split_en          (cfg_split_en),
        .x_burst_arvld_disable (x_burst_arvld_disable),
        .dma_req_valid         (dma_req_valid),
        .dma_req_ready         (dma_req_ready),
        .dma_req_addr          (dma_req_addr),
        .dma_req_len           (dma_req_len),
        .dma_xaddr_burst_ok    (dma_xaddr_burst_ok),
        .o_axvalid             (o_axvalid),
        .o_axid                (o_axid),
        .o_axaddr              (o_axaddr),
        .o_axlen               (o_axlen),
        .o_axsize              (o_axsize),
        .o_axburst             (o_axburst),
        .o_axlock              (o_axlock),
        .o_axcache             (o_axcache),
        .o_axprot              (o_axprot),
        .i_axready             (i_axready),
        .info_valid            (info_valid),
        .info_ready            (info_ready),
        .info_len              (info_len),
        .info_last             (info_last),
`ifdef AXI_SPLIT_STAT_EN
        .stat_clr              (stat_clr),
        .stat_req_cnt          (stat_req_cnt),
        .stat_piece_cnt        (stat_piece_cnt),
`endif
        .split_active          (split_active)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // AX monitor: every address handshake must match the next queued piece.
    always @(negedge aclk) begin
        if (aresetn && o_axvalid && i_axready) begin
            if (exp_ax.size() == 0) begin
                check_output("ax_unexpected", 64'(o_axaddr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ax_e = exp_ax.pop_front();
                check_output("ax_addr", 64'(o_axaddr), 64'(ax_e[39:8]));
                check_output("ax_len", 64'(o_axlen), 64'(ax_e[7:0]));
            end
        end
    end

    // Descriptor monitor: every FIFO pop must match the next queued descriptor.
    always @(negedge aclk) begin
        if (aresetn && info_valid && info_ready) begin
            if (exp_info.size() == 0) begin
                check_output("info_unexpected", 64'(info_len), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                info_e = exp_info.pop_front();
                check_output("info_len", 64'(info_len), 64'(info_e[8:1]));
                check_output("info_last", 64'(info_last), 64'(info_e[0]));
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn && dma_xaddr_burst_ok) ok_seen++;
    end

    // All stimulus tasks start and end at 1 time unit after a rising edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic expect_piece(input logic [31:0] a, input logic [7:0] l, input logic last);
        exp_ax.push_back({a, l});
        exp_info.push_back({l, last});
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [7:0] l);
        logic hs;
        hs            = 1'b0;
        dma_req_addr  = a;
        dma_req_len   = l;
        dma_req_valid = 1'b1;
        for (int n = 0; n < 300 && !hs; n++) begin
            @(negedge aclk);
            hs = dma_req_ready;
            step();
        end
        dma_req_valid = 1'b0;
        if (!hs) check_output("req_accept_timeout", 64'(hs), 64'd1);
    endtask

    task automatic wait_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge aclk);
            seen = o_axvalid;
            step();
        end
        if (!seen) check_output(name, 64'(seen), 64'd1);
    endtask

    task automatic pulse_axready();
        i_axready = 1'b1;
        step();
        i_axready = 1'b0;
    endtask

    task automatic wait_ok(input int target);
        for (int n = 0; n < 500 && ok_seen < target; n++) step();
        check_output("ok_count", 64'(ok_seen), 64'(target));
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && (exp_ax.size() != 0 || exp_info.size() != 0); n++) step();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn               = 1'b0;
        cfg_split_en          = 1'b1;
        x_burst_arvld_disable = 1'b0;
        dma_req_valid         = 1'b0;
        dma_req_addr          = '0;
        dma_req_len           = '0;
        i_axready             = 1'b1;
        info_ready            = 1'b1;
`ifdef AXI_SPLIT_STAT_EN
        stat_clr              = 1'b0;
`endif

        // Reset state.
        repeat (2) @(negedge aclk);
        check_output("rst_axvalid", 64'(o_axvalid), 64'd0);
        check_output("rst_axaddr", 64'(o_axaddr), 64'd0);
        check_output("rst_axlen", 64'(o_axlen), 64'd0);
        check_output("rst_req_ready", 64'(dma_req_ready), 64'd0);
        check_output("rst_ok", 64'(dma_xaddr_burst_ok), 64'd0);
        check_output("rst_info_valid", 64'(info_valid), 64'd0);
        check_output("rst_split_active", 64'(split_active), 64'd0);
        check_output("axsize", 64'(o_axsize), 64'd5);
        check_output("axburst", 64'(o_axburst), 64'd1);
        step();
        aresetn = 1'b1;
        step();

        // Triple split: 0x0F00, 256 beats.
        expect_piece(32'h0000_0F00, 8'd7, 1'b0);
        expect_piece(32'h0000_1000, 8'd127, 1'b0);
        expect_piece(32'h0000_2000, 8'd119, 1'b1);
        ok_exp++;
        apply_stimulus(32'h0000_0F00, 8'd255);
        check_output("triple_split_active", 64'(split_active), 64'd1);
        wait_ok(ok_exp);
        check_output("triple_split_cleared", 64'(split_active), 64'd0);
        drain();

        // Single-beat head: 0x1FE0, 4 beats.
        expect_piece(32'h0000_1FE0, 8'd0, 1'b0);
        expect_piece(32'h0000_2000, 8'd2, 1'b1);
        ok_exp++;
        apply_stimulus(32'h0000_1FE0, 8'd3);
        check_output("head_split_active", 64'(split_active), 64'd1);
        wait_ok(ok_exp);
        drain();

        // Exact fit: ends exactly on the boundary, not split.
        expect_piece(32'h0000_0E00, 8'd15, 1'b1);
        ok_exp++;
        apply_stimulus(32'h0000_0E00, 8'd15);
        check_output("fit_split_active", 64'(split_active), 64'd0);
        wait_ok(ok_exp);
        drain();

        // Splitting disabled: whole burst passes through.
        cfg_split_en = 1'b0;
        expect_piece(32'h0000_0F00, 8'd255, 1'b1);
        ok_exp++;
        apply_stimulus(32'h0000_0F00, 8'd255);
        check_output("nosplit_split_active", 64'(split_active), 64'd0);
        wait_ok(ok_exp);
        drain();
        cfg_split_en = 1'b1;

        // Acceptance gate.
        x_burst_arvld_disable = 1'b1;
        @(negedge aclk);
        check_output("disable_ready", 64'(dma_req_ready), 64'd0);
        step();
        x_burst_arvld_disable = 1'b0;
        @(negedge aclk);
        check_output("enable_ready", 64'(dma_req_ready), 64'd1);
        step();

        // Backpressure on piece 2 for 5 cycles.
        i_axready = 1'b0;
        expect_piece(32'h0000_0F00, 8'd7, 1'b0);
        expect_piece(32'h0000_1000, 8'd127, 1'b0);
        expect_piece(32'h0000_2000, 8'd119, 1'b1);
        ok_exp++;
        apply_stimulus(32'h0000_0F00, 8'd255);
        wait_valid("bp_piece1_timeout");
        pulse_axready();
        wait_valid("bp_piece2_timeout");
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            check_output("bp_hold_valid", 64'(o_axvalid), 64'd1);
            check_output("bp_hold_addr", 64'(o_axaddr), 64'h1000);
            check_output("bp_hold_len", 64'(o_axlen), 64'd127);
            step();
        end
        i_axready = 1'b1;
        wait_ok(ok_exp);
        drain();

        // FIFO full: no pops, triple split plus one single-beat request.
        info_ready = 1'b0;
        expect_piece(32'h0000_0F00, 8'd7, 1'b0);
        expect_piece(32'h0000_1000, 8'd127, 1'b0);
        expect_piece(32'h0000_2000, 8'd119, 1'b1);
        expect_piece(32'h0000_0000, 8'd0, 1'b1);
        ok_exp += 2;
        apply_stimulus(32'h0000_0F00, 8'd255);
        apply_stimulus(32'h0000_0000, 8'd0);
        wait_ok(ok_exp);
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            check_output("full_ready_low", 64'(dma_req_ready), 64'd0);
            check_output("full_info_valid", 64'(info_valid), 64'd1);
            step();
        end
        info_ready = 1'b1;
        step();
        info_ready = 1'b0;
        @(negedge aclk);
        check_output("full_ready_back", 64'(dma_req_ready), 64'd1);
        step();
        expect_piece(32'h0000_0040, 8'd0, 1'b1);
        ok_exp++;
        apply_stimulus(32'h0000_0040, 8'd0);
        info_ready = 1'b1;
        wait_ok(ok_exp);
        drain();

        // Reset while piece 2 is presented; remaining pieces are dropped.
        i_axready = 1'b0;
        expect_piece(32'h0000_0F00, 8'd7, 1'b0);
        expect_piece(32'h0000_1000, 8'd127, 1'b0);
        expect_piece(32'h0000_2000, 8'd119, 1'b1);
        apply_stimulus(32'h0000_0F00, 8'd255);
        wait_valid("mrst_piece1_timeout");
        pulse_axready();
        wait_valid("mrst_piece2_timeout");
        aresetn = 1'b0;
        exp_ax.delete();
        exp_info.delete();
        i_axready = 1'b1;
        @(negedge aclk);
        check_output("mrst_axvalid", 64'(o_axvalid), 64'd0);
        check_output("mrst_axaddr", 64'(o_axaddr), 64'd0);
        check_output("mrst_axlen", 64'(o_axlen), 64'd0);
        check_output("mrst_info_valid", 64'(info_valid), 64'd0);
        check_output("mrst_split_active", 64'(split_active), 64'd0);
        check_output("mrst_req_ready", 64'(dma_req_ready), 64'd0);
        step();
        aresetn = 1'b1;
        step();
        expect_piece(32'h0000_1FE0, 8'd0, 1'b0);
        expect_piece(32'h0000_2000, 8'd2, 1'b1);
        ok_exp++;
        apply_stimulus(32'h0000_1FE0, 8'd3);
        wait_ok(ok_exp);
        drain();

        repeat (5) step();
        check_output("ax_queue_empty", 64'(exp_ax.size()), 64'd0);
        check_output("info_queue_empty", 64'(exp_info.size()), 64'd0);
        check_output("ok_total", 64'(ok_seen), 64'(ok_exp));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
